// File: rtl/fetch_run_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_run_ctrl
//   Run control and fetch latch sitting beside the PC generator. A program is
//   started by pulsing start_o with start_addr_o into the PC stage. While
//   running, the word the ROM returns for pc_i is registered for decode, so
//   instr_o always lags the PC by one cycle. The run ends on the halt opcode
//   (which is never issued) or when the cycle budget runs out. done_o is then
//   held until req_i drops.
//
// Ports
//   clk            clock, all state on posedge
//   rst_n          async active-low reset
//   req_i          level request to run a program
//   prog_sel_i     program select (sampled in IDLE when req_i=1)
//   pc_i           current PC from the PC stage
//   instr_in_i     combinational ROM data for pc_i
//   start_o        PC stage loads start_addr_o on the next edge
//   start_addr_o   program start address
//   instr_o        registered instruction for decode
//   instr_pc_o     PC that instr_o was fetched from
//   instr_valid_o  instr_o / instr_pc_o valid this cycle
//   done_o         program finished, held until req_i=0
//   timeout_o      finish was caused by the cycle budget (valid with done_o)
//   cycle_count_o  RUN edges counted for the current/last program
// ---------------------------------------------------------------------------
module fetch_run_ctrl #(
  parameter int unsigned      IW         = 9,
  parameter logic [IW-1:0]    HALT_OP    = 9'h1FF,
  parameter logic [15:0]      MAX_CYCLES = 16'hFFFF,
  parameter logic [7:0]       ADDR0      = 8'd0,
  parameter logic [7:0]       ADDR1      = 8'd64,
  parameter logic [7:0]       ADDR2      = 8'd128,
  parameter logic [7:0]       ADDR3      = 8'd192
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic [1:0]    prog_sel_i,
  input  logic [7:0]    pc_i,
  input  logic [IW-1:0] instr_in_i,
  output logic          start_o,
  output logic [7:0]    start_addr_o,
  output logic [IW-1:0] instr_o,
  output logic [7:0]    instr_pc_o,
  output logic          instr_valid_o,
  output logic          done_o,
  output logic          timeout_o,
  output logic [15:0]   cycle_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          start_q, start_d;
  logic [7:0]    start_addr_q, start_addr_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [7:0]    instr_pc_q, instr_pc_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          is_halt;
  logic [15:0]   cnt_inc;
  logic [7:0]    sel_addr;

  assign is_halt = (instr_in_i == HALT_OP);
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    sel_addr = ADDR0;
    case (prog_sel_i)
      2'd0: sel_addr = ADDR0;
      2'd1: sel_addr = ADDR1;
      2'd2: sel_addr = ADDR2;
      2'd3: sel_addr = ADDR3;
      default: sel_addr = ADDR0;
    endcase
  end

  // State register together with the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      start_addr_q <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      start_addr_q <= start_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_i) state_d = S_START;
      S_START: state_d = S_RUN;
      // req_i is deliberately ignored here: a run always ends by halt/timeout.
      S_RUN:   if (is_halt || cnt_inc == MAX_CYCLES) state_d = S_DONE;
      // Leaving DONE needs req_i low, so a held request cannot restart.
      S_DONE:  if (!req_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values.
  always_comb begin
    start_d      = start_q;
    start_addr_d = start_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = 1'b0;
    done_d       = done_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          start_d      = 1'b1;
          start_addr_d = sel_addr;
          cnt_d        = '0;
          timeout_d    = 1'b0;
          done_d       = 1'b0;
        end
      end
      S_START: begin
        start_d = 1'b0;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        // Halt wins over timeout; in both cases the current word is dropped.
        if (is_halt) begin
          done_d = 1'b1;
        end else if (cnt_inc == MAX_CYCLES) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          instr_d    = instr_in_i;
          instr_pc_d = pc_i;
          valid_d    = 1'b1;
        end
      end
      S_DONE: begin
        if (!req_i) done_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign start_o       = start_q;
  assign start_addr_o  = start_addr_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_run_ctrl.sv
module tb_fetch_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared ROM, combinational read
  logic [8:0] rom [256];

  // main DUT (default budget)
  logic       req = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] pc;
  logic       start, valid, done, tmo;
  logic [7:0] saddr, ipc;
  logic [8:0] instr;
  logic [15:0] cnt;

  // second DUT with a 5-cycle budget
  logic       req5 = 1'b0;
  logic [1:0] sel5 = 2'd2;
  logic [7:0] pc5;
  logic       start5, valid5, done5, tmo5;
  logic [7:0] saddr5, ipc5;
  logic [8:0] instr5;
  logic [15:0] cnt5;

  // free-running PC stage models
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= 8'd0;
    else        pc <= start ? saddr : pc + 8'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc5 <= 8'd0;
    else        pc5 <= start5 ? saddr5 : pc5 + 8'd1;

  fetch_run_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .prog_sel_i(sel), .pc_i(pc),
    .instr_in_i(rom[pc]), .start_o(start), .start_addr_o(saddr), .instr_o(instr),
    .instr_pc_o(ipc), .instr_valid_o(valid), .done_o(done), .timeout_o(tmo),
    .cycle_count_o(cnt));

  fetch_run_ctrl #(.MAX_CYCLES(16'd5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req_i(req5), .prog_sel_i(sel5), .pc_i(pc5),
    .instr_in_i(rom[pc5]), .start_o(start5), .start_addr_o(saddr5), .instr_o(instr5),
    .instr_pc_o(ipc5), .instr_valid_o(valid5), .done_o(done5), .timeout_o(tmo5),
    .cycle_count_o(cnt5));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int nv;
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    rom[0]   = 9'h1FF;              // prog 0: halt first
    rom[64]  = 9'h010; rom[65] = 9'h011; rom[66] = 9'h1FF;
    rom[192] = 9'h055; rom[193] = 9'h1FF;
    // 128.. left non-halt for the timeout run

    // reset state
    #2;
    chk("rst_start", start, 0); chk("rst_saddr", saddr, 0); chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);   chk("rst_tmo", tmo, 0);     chk("rst_cnt", cnt, 0);
    chk("rst_instr", instr, 0); chk("rst_ipc", ipc, 0);
    #10 rst_n = 1'b1;           // t=12, between edges

    // program 1: 010, 011, HALT ; Req stays high through DONE
    req = 1'b1; sel = 2'd1;
    tick();
    chk("p1_start", start, 1); chk("p1_saddr", saddr, 64); chk("p1_v0", valid, 0);
    tick();
    chk("p1_start_lo", start, 0); chk("p1_v1", valid, 0); chk("p1_pc", pc, 64);
    tick();
    chk("p1_v2", valid, 1); chk("p1_i0", instr, 9'h010); chk("p1_ipc0", ipc, 64);
    tick();
    chk("p1_v3", valid, 1); chk("p1_i1", instr, 9'h011); chk("p1_ipc1", ipc, 65);
    tick();
    chk("p1_v4", valid, 0); chk("p1_done", done, 1); chk("p1_tmo", tmo, 0);
    chk("p1_cnt", cnt, 3);
    tick(4);
    chk("p1_hold_done", done, 1); chk("p1_no_restart", start, 0); chk("p1_hold_cnt", cnt, 3);
    chk("p1_hold_v", valid, 0);
    req = 1'b0;
    tick();
    chk("p1_done_clr", done, 0); chk("p1_idle_start", start, 0);
    tick(2);
    chk("p1_idle_stay", start, 0);

    // program 0: first word halt; Req dropped during START (ignored)
    req = 1'b1; sel = 2'd0;
    tick();
    chk("p0_start", start, 1); chk("p0_saddr", saddr, 0); chk("p0_cnt_clr", cnt, 0);
    req = 1'b0;
    tick();
    chk("p0_start_lo", start, 0);
    tick();
    chk("p0_done", done, 1); chk("p0_v", valid, 0); chk("p0_cnt", cnt, 1); chk("p0_tmo", tmo, 0);
    tick();
    chk("p0_idle", done, 0);

    // program 3: Start_Addr 192, count cleared
    req = 1'b1; sel = 2'd3;
    tick();
    chk("p3_start", start, 1); chk("p3_saddr", saddr, 192); chk("p3_cnt_clr", cnt, 0);
    tick(2);
    chk("p3_v", valid, 1); chk("p3_i", instr, 9'h055); chk("p3_ipc", ipc, 192);
    tick();
    chk("p3_done", done, 1); chk("p3_cnt", cnt, 2);
    req = 1'b0;
    tick();

    // timeout with MAX_CYCLES=5, program at 128 has no halt
    req5 = 1'b1; sel5 = 2'd2;
    tick();
    chk("to_start", start5, 1); chk("to_saddr", saddr5, 128);
    tick();
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (valid5) nv++;
    end
    chk("to_nvalid", nv, 4);
    chk("to_done", done5, 1); chk("to_tmo", tmo5, 1); chk("to_cnt", cnt5, 5);
    chk("to_v", valid5, 0); chk("to_ipc", ipc5, 131);
    req5 = 1'b0;
    tick();
    chk("to_idle", done5, 0);

    // async reset mid-run
    req = 1'b1; sel = 2'd1;
    tick(3);
    chk("mr_running", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", valid, 0); chk("mr_start", start, 0); chk("mr_saddr", saddr, 0);
    chk("mr_instr", instr, 0); chk("mr_ipc", ipc, 0); chk("mr_cnt", cnt, 0);
    chk("mr_done", done, 0); chk("mr_tmo", tmo, 0);
    req = 1'b0;
    #2 rst_n = 1'b1;
    tick(2);
    chk("mr_idle_start", start, 0); chk("mr_idle_v", valid, 0);
    req = 1'b1; sel = 2'd1;
    tick();
    chk("mr_restart", start, 1); chk("mr_restart_addr", saddr, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
